// File: rtl/fifo_write_arbiter.sv
//------------------------------------------------------------------------------
// Module  : fifo_write_arbiter
// Brief   : Two-requester write arbiter in front of a FIFO. It uses bounded
//           bursts, round-robin tie-breaking and a one-cycle bubble whenever
//           a burst ends.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module fifo_write_arbiter #(
  parameter int DATA_WIDTH = 128,
  parameter int BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0Valid,
  input  logic [DATA_WIDTH-1:0] req0Data,
  output logic                  req0Ready,
  input  logic                  req1Valid,
  input  logic [DATA_WIDTH-1:0] req1Data,
  output logic                  req1Ready,
  input  logic                  fifoFull,
  output logic                  fifoWrite,
  output logic [DATA_WIDTH-1:0] fifoData,
  output logic [1:0]            grant
);

  // State encoding doubles as the one-hot grant vector.
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_GNT0 = 2'b01;
  localparam logic [1:0] S_GNT1 = 2'b10;

  localparam logic [3:0] c_BURST_LEN = BURST_LEN[3:0];

  logic [1:0] r_state;
  logic [3:0] r_count;
  logic       r_last;      // requester served most recently (1 after reset)

  logic [1:0] w_state_nxt;
  logic [3:0] w_count_nxt;
  logic       w_last_nxt;
  logic       w_burst_done;
  logic       w_xfer0;
  logic       w_xfer1;

  // A burst that has reached its limit spends one cycle with readies low.
  // During that cycle the arbiter decides whether to switch requesters.
  assign w_burst_done = (r_count == c_BURST_LEN);

  assign req0Ready = (r_state == S_GNT0) & ~fifoFull & ~w_burst_done;
  assign req1Ready = (r_state == S_GNT1) & ~fifoFull & ~w_burst_done;
  assign w_xfer0   = req0Valid & req0Ready;
  assign w_xfer1   = req1Valid & req1Ready;
  assign fifoWrite = w_xfer0 | w_xfer1;
  assign grant     = r_state;

  // Present the granted requester's word and drive zeros while idle.
  always_comb begin
    case (r_state)
      S_GNT0:  fifoData = req0Data;
      S_GNT1:  fifoData = req1Data;
      default: fifoData = '0;
    endcase
  end

  // Next-state, burst counter and last-served decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_last_nxt  = r_last;
    case (r_state)
      S_IDLE: begin
        if (req0Valid && req1Valid) begin
          w_state_nxt = r_last ? S_GNT0 : S_GNT1;
        end else if (req0Valid) begin
          w_state_nxt = S_GNT0;
        end else if (req1Valid) begin
          w_state_nxt = S_GNT1;
        end
        w_count_nxt = 4'd0;
      end
      S_GNT0: begin
        // A full FIFO freezes everything, including the burst count.
        if (!fifoFull) begin
          if (!req0Valid) begin
            w_state_nxt = req1Valid ? S_GNT1 : S_IDLE;
            w_last_nxt  = 1'b0;
            w_count_nxt = 4'd0;
          end else if (w_burst_done) begin
            if (req1Valid) begin
              w_state_nxt = S_GNT1;
              w_last_nxt  = 1'b0;
            end
            w_count_nxt = 4'd0;
          end else if (w_xfer0) begin
            w_count_nxt = r_count + 4'd1;
          end
        end
      end
      S_GNT1: begin
        if (!fifoFull) begin
          if (!req1Valid) begin
            w_state_nxt = req0Valid ? S_GNT0 : S_IDLE;
            w_last_nxt  = 1'b1;
            w_count_nxt = 4'd0;
          end else if (w_burst_done) begin
            if (req0Valid) begin
              w_state_nxt = S_GNT0;
              w_last_nxt  = 1'b1;
            end
            w_count_nxt = 4'd0;
          end else if (w_xfer1) begin
            w_count_nxt = r_count + 4'd1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_count_nxt = 4'd0;
      end
    endcase
  end

  // State registers. Reset makes requester 0 the preferred requester.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_count <= 4'd0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_last  <= w_last_nxt;
    end
  end

endmodule

`default_nettype wire

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 128, width of each requester data bus and the FIFO write data bus.
REQ-002 Parameter BURST_LEN, default 4, maximum consecutive writes one requester may make while the other waits; legal range 1..15.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req0Valid  input  1  requester 0 holds a word on req0Data.
REQ-006 req0Data  input  DATA_WIDTH  requester 0 write word.
REQ-007 req0Ready  output  1  requester 0 word accepted this cycle when req0Valid is also high.
REQ-008 req1Valid  input  1  requester 1 holds a word on req1Data.
REQ-009 req1Data  input  DATA_WIDTH  requester 1 write word.
REQ-010 req1Ready  output  1  requester 1 word accepted this cycle when req1Valid is also high.
REQ-011 fifoFull  input  1  full flag from the downstream fifo_buffer.
REQ-012 fifoWrite  output  1  write strobe to fifo_buffer.write.
REQ-013 fifoData  output  DATA_WIDTH  data to fifo_buffer.dataIn.
REQ-014 grant  output  2  one-hot current grant: bit0 = requester 0, bit1 = requester 1, 00 = idle.

Function
REQ-015 The arbiter SHALL implement three states: IDLE, GNT0, GNT1; grant SHALL equal 00, 01 and 10 respectively.
REQ-016 Transfer for requester x SHALL be reqxValid & reqxReady; reqxReady SHALL be high only in GNTx with fifoFull low.
REQ-017 fifoWrite SHALL equal the transfer of the granted requester, combinationally, in the same cycle.
REQ-018 fifoData SHALL equal the granted requester's data in GNT0/GNT1 and all zeros in IDLE.
REQ-019 Requesters SHALL hold valid and data stable until accepted; the arbiter SHALL NOT rely on early valid withdrawal.
REQ-020 IDLE: one valid -> grant that requester next cycle; both valid -> grant the requester not equal to lastServed; none valid -> stay IDLE.
REQ-021 Arbitration latency SHALL be one cycle: no transfer in IDLE; the first write occurs at the earliest one cycle after valid rises.
REQ-022 A 4-bit burst counter SHALL increment on each transfer in GNTx and clear on every state change.
REQ-023 GNTx with reqxValid low: go GNTy if reqyValid high, else IDLE.
REQ-024 GNTx with transfer making the count equal BURST_LEN: go GNTy if reqyValid high; otherwise stay in GNTx and clear the counter.
REQ-025 GNTx with fifoFull high: state, counter and lastServed SHALL hold; no write, both readies low.
REQ-026 lastServed SHALL update to x whenever the arbiter leaves GNTx.
REQ-027 The arbiter SHALL never assert fifoWrite while fifoFull is high, and never both readies at once.

Reset
REQ-028 rst high SHALL immediately force IDLE, counter 0, lastServed = 1, grant = 00, fifoWrite = 0, req0Ready = req1Ready = 0, fifoData = 0, independent of clk.
REQ-029 Reset asserted mid-burst SHALL discard the burst; after release, arbitration restarts from IDLE with requester 0 preferred.

Verification
REQ-030 Reset, req0Valid=1, req0Data=0x1111..11, fifoFull=0 -> grant=01 on cycle 1, fifoWrite=1 with fifoData=0x1111..11 on cycle 1, req1Ready=0 throughout.
REQ-031 Both valid continuously, BURST_LEN=4, data 0xA..A and 0xB..B -> writes A,A,A,A, one idle switch cycle, B,B,B,B, switch, A...; grant alternates 01/10.
REQ-032 GNT0 with fifoFull=1 for 3 cycles -> fifoWrite=0, req0Ready=0, grant stays 01, burst count unchanged; write resumes on the first cycle fifoFull=0.
REQ-033 Only req1 valid for 10 words -> 10 writes with one-cycle turnaround every 4 words, grant stays 10, no switch to requester 0.
REQ-034 Assert rst for a partial cycle during GNT1 after 2 writes -> outputs zero asynchronously; after release with both valid, requester 0 granted first.
REQ-035 Arbiter wired to fifo_buffer (8 deep), both requesters writing 0x1..1..0x8..8 alternating, reader draining -> fifo dataOut order matches fifoWrite order exactly, full never violated.
